// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_pkg;

  // Default operand/result width.
  localparam int SERIAL_SUB_N_DEF = 8;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_fs_structural.sv
// 1-bit full subtractor built from gate primitives.
//   dbit = x ^ y ^ bin
//   bout = (~x & y) | (~(x ^ y) & bin)
module fs_structural (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic dbit,
  output logic bout
);

  logic x_xor_y;
  logic x_n;
  logic xnor_xy;
  logic borrow_gen;
  logic borrow_prop;

  xor g_xor0 (x_xor_y, x, y);
  xor g_xor1 (dbit, x_xor_y, bin);
  not g_not0 (x_n, x);
  and g_and0 (borrow_gen, x_n, y);
  not g_not1 (xnor_xy, x_xor_y);
  and g_and1 (borrow_prop, xnor_xy, bin);
  or  g_or0  (bout, borrow_gen, borrow_prop);

endmodule : fs_structural

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: d = x - y - bin, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = SERIAL_SUB_N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int            CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   xr;
  logic [N-1:0]   yr;
  logic [N-1:0]   dr;
  logic           br;
  logic [CW-1:0]  cnt;
  logic           dbit;
  logic           bnext;
  logic           last_step;

`ifdef SERIAL_SUB_OVF_EN
  logic           x_msb;
  logic           y_msb;
`endif

  // Single shared subtractor cell working on the current LSBs and borrow.
  fs_structural u_fs (
    .x    (xr[0]),
    .y    (yr[0]),
    .bin  (br),
    .dbit (dbit),
    .bout (bnext)
  );

  assign last_step = (state_q == ST_SHIFT) && (cnt == CNT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand load, bit-serial shift and result capture on the final step.
  // NOTE: every datapath register, results included, is cleared by reset so
  // no stale value from an aborted operation is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr   <= '0;
      yr   <= '0;
      dr   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      d    <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            xr  <= x;
            yr  <= y;
            br  <= bin;
            cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            x_msb <= x[N-1];
            y_msb <= y[N-1];
`endif
          end
        end
        ST_SHIFT: begin
          dr <= {dbit, dr[N-1:1]};
          xr <= {1'b0, xr[N-1:1]};
          yr <= {1'b0, yr[N-1:1]};
          br <= bnext;
          // Counter stops at N-1 instead of wrapping.
          if (!last_step) cnt <= cnt + 1'b1;
          if (last_step) begin
            d    <= {dbit, dr[N-1:1]};
            bout <= bnext;
`ifdef SERIAL_SUB_OVF_EN
            ovf  <= (x_msb != y_msb) && (dbit != x_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule : serial_subtractor

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing d = x − y − bin one bit per clock, LSB first. It reuses a single 1-bit full-subtractor cell with a registered borrow. It is the sequential counterpart to the 1-bit full-adder cell in the combinational adder group. It sits wherever area matters more than latency, and is driven by a simple start/done handshake.

## Interface
- N, default 8: operand and result width in bits (N ≥ 2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- x  input  N  minuend; sampled on the edge that accepts start.
- y  input  N  subtrahend; sampled with x.
- bin  input  1  borrow-in; sampled with x.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; result valid.
- d  output  N  difference, registered; holds until the next done.
- bout  output  1  borrow-out, registered; holds with d.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- Arithmetic:
  - d = (x − y − bin) mod 2^N.
  - bout = 1 iff x < y + bin (unsigned comparison).
- States:
  - IDLE: start=1 loads xr←x, yr←y, br←bin and cnt←0, then goes to SHIFT. start=0 stays in IDLE.
  - SHIFT: each edge does the following, and goes to DONE when cnt == N−1:
    - fs cell computes (xr[0], yr[0], br) → (dbit, bnext).
    - dr shifts right with dbit inserted at the MSB.
    - xr and yr shift right; br←bnext; cnt←cnt+1.
  - DONE: goes to IDLE unconditionally on the next edge.
- Output update: on the edge entering DONE, d←final dr and bout←final borrow. ovf is updated on the same edge when enabled.
- done = (state == DONE).
- busy = (state ≠ IDLE).
- Boundary conditions:
  - start asserted while busy (SHIFT or DONE) is ignored. x, y and bin changes during SHIFT have no effect.
  - cnt is ceil(log2 N) bits wide. It is compared against N−1 and never wraps.
  - Operands x = y with bin = 0 give d = 0, bout = 0. bin = 1 with x = y gives all-ones, bout = 1.
  - Reset asserted in any state returns to IDLE immediately and clears all registers, including d and bout. There is no partial result.

## Timing
- Edge E0 samples start=1 in IDLE.
- Edges E1..EN perform the N bit steps. EN enters DONE and registers d, bout and ovf.
- done is high for exactly one cycle, from EN to EN+1.
- busy is high from E0 to EN+1.
- The earliest next accepted start is at edge EN+2. Throughput is one operation per N+2 cycles.
- Reset values: busy=0, done=0, d=0, bout=0, ovf=0, state=IDLE.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - Port ovf exists.
  - ovf is computed as ovf = (x[N−1] ≠ y[N−1]) & (d[N−1] ≠ x[N−1]), using the latched operand MSBs and the final dr MSB.
  - ovf is registered with d.
- SERIAL_SUB_OVF_EN undefined: the ovf port and its logic are absent. Everything else is identical.

## Structure
- Package serial_sub_pkg:
  - state encoding constants ST_IDLE, ST_SHIFT, ST_DONE (2 bits);
  - default width constant SERIAL_SUB_N_DEF = 8.
- Sub-module fs_structural: the 1-bit full subtractor. It is combinational and built structurally from gates.
  - Ports x, y, bin, dbit, bout.
  - dbit = x^y^bin.
  - bout = (~x&y) | (~(x^y)&bin).
- Top level: FSM, shift registers, borrow flop, counter, output registers.

## Test plan
- N=8, x=100, y=37, bin=0, start at E0 → done high only in cycle EN..EN+1 (E8..E9); d=63, bout=0; busy high E0..E9.
- x=5, y=9, bin=0 → d=8'hFC, bout=1. Then x=0, y=0, bin=1 → d=8'hFF, bout=1.
- With SERIAL_SUB_OVF_EN:
  - x=8'h80, y=8'h01 → d=8'h7F, bout=0, ovf=1.
  - x=8'h10, y=8'h01 → d=8'h0F, ovf=0.
- Start pulsed during SHIFT with different x/y → ignored; the first result is unchanged. A start held high continuously is accepted again exactly at E10 (N+2 period).
- Reset asserted mid-SHIFT (after E4) → busy, done, d, bout go to 0 immediately without waiting for a clock edge. After release, x=8'hFF, y=8'hFF, bin=0 → d=0, bout=0.
- Exhaustive N=4 sweep of all x, y, bin → d and bout match the reference model (x − y − bin) for every case.
